pc_sequencer: RTL

- Next-generation program-counter block for the single-cycle MIPS core.
- Replaces the combinational jump mux and separate PC register with one registered sequencer.
- Selects among sequential, branch, jump, register-jump, exception and exception-return targets by fixed priority.
- Adds stall, an exception PC (EPC) register and a parametrised return-address stack (RAS) that flags jr-$ra mispredictions for the future pipelined core.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/ras_stack.sv | 51 +++++
 rtl/pc_sequencer.sv | 89 ++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared constants and next-PC select encoding for the MIPS program-counter path.
package mips_pkg;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_0180;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_J,
    SEL_JR,
    SEL_EXC,
    SEL_ERET
  } sel_t;

  // Fixed priority: exc > eret > jump_reg > jump > branch > sequential.
  function automatic sel_t next_sel(input logic exc, input logic eret, input logic jump_reg,
                                    input logic jump, input logic branch_taken);
    if (exc)               return SEL_EXC;
    else if (eret)         return SEL_ERET;
    else if (jump_reg)     return SEL_JR;
    else if (jump)         return SEL_J;
    else if (branch_taken) return SEL_BR;
    else                   return SEL_SEQ;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push, pop, and combined pop+push that replaces the top entry.
module ras_stack
  import mips_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             valid,
  output logic [WIDTH-1:0] popped
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]    ptr;
  logic [CW-1:0]    count;
  logic [PW-1:0]    ptr_inc;
  logic [PW-1:0]    ptr_dec;

  assign ptr_inc = ptr + PW'(1);
  assign ptr_dec = ptr - PW'(1);
  assign valid   = (count != '0);
  assign top     = valid ? mem[ptr] : '0;
  assign popped  = mem[ptr];

  // When full, the pointer wraps onto the oldest entry and overwrites it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) mem[i] <= '0;
    end else if (push && pop && valid) begin
      mem[ptr] <= push_data;
    end else if (push) begin
      ptr          <= ptr_inc;
      mem[ptr_inc] <= push_data;
      if (count != CW'(RAS_DEPTH)) count <= count + CW'(1);
    end else if (pop && valid) begin
      ptr   <= ptr_dec;
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program-counter sequencer with stall, EPC and return-address prediction check.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_VECTOR_DEF),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(EXC_VECTOR_DEF),
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_offset,
  input  logic             jump,
  input  logic [25:0]      jaddr,
  input  logic             jump_reg,
  input  logic [WIDTH-1:0] reg_target,
  input  logic             link,
  input  logic             ret,
  input  logic             exc,
  input  logic             eret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] ras_top,
  output logic             ras_valid,
  output logic             ras_mispredict
);

  sel_t             sel;
  logic [WIDTH-1:0] pc_next;
  logic             advance;
  logic             ras_push;
  logic             ras_pop;
  logic [WIDTH-1:0] ras_popped;

  assign pc_plus4 = pc + WIDTH'(4);
  assign sel      = next_sel(exc, eret, jump_reg, jump, branch_taken);
  assign advance  = !stall && !exc;
  assign ras_push = link && advance;
  assign ras_pop  = jump_reg && ret && advance;

  always_comb begin
    pc_next = pc_plus4;
    case (sel)
      SEL_EXC:  pc_next = EXC_VECTOR;
      SEL_ERET: pc_next = epc;
      SEL_JR:   pc_next = reg_target;
      SEL_J:    pc_next = {pc_plus4[WIDTH-1:28], jaddr, 2'b00};
      SEL_BR:   pc_next = pc_plus4 + (branch_offset << 2);
      default:  pc_next = pc_plus4;
    endcase
  end

  // Exceptions are taken even while stalled; everything else holds under stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc  <= RESET_VECTOR;
      epc <= '0;
    end else if (exc) begin
      pc  <= EXC_VECTOR;
      epc <= pc;
    end else if (!stall) begin
      pc <= pc_next;
    end
  end

  // Mispredict is judged against the entry being popped, before any same-cycle replace.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ras_mispredict <= 1'b0;
    else       ras_mispredict <= ras_pop && ras_valid && (ras_popped != reg_target);
  end

  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus4),
    .top       (ras_top),
    .valid     (ras_valid),
    .popped    (ras_popped)
  );

endmodule
